// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver. It supports 5..9 data bits, optional odd or
//   even parity, and 1 or 2 stop bits. It rejects glitches on the start bit,
//   flags parity and framing errors, and handles a held line break.
//
// Parameters
//   CLK_FREQ     system clock in Hz
//   BAUD_RATE    line rate in bit/s (CLK_FREQ/BAUD_RATE must be >= 4)
//   DATA_BITS    data bits per frame, 5..9
//   PARITY       0 = none, 1 = odd, 2 = even
//   STOP_BITS    1 or 2
//   SYNC_STAGES  synchroniser depth on rx, >= 2
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx          serial line, idle high, LSB first
//   data_out    last received word, held until the next frame completes
//   data_valid  one-cycle pulse when a frame completes
//   parity_err  parity mismatch on the last frame (0 when PARITY = 0)
//   frame_err   a stop bit was sampled low on the last frame
//   busy        high from start detection until the return to IDLE
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;

  // The clock counter holds the cycle index inside the current bit, starting
  // at 1. Bit 0 is sampled at half a bit period. Every later bit is sampled
  // one full period after the previous sample. The extra counter bit lets
  // the counter hold CLKS_PER_BIT itself.
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic                   rx_s;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   data_valid_q, data_valid_d;

  logic                   sample;
  logic                   par_exp;
  logic                   ferr_now;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // The synchroniser and the edge-history flop reset to the idle level (1),
  // so releasing reset never produces a false start edge.
  // NOTE: sequential state is written only with non-blocking assignments.
  //       All flops then update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_out_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      data_out_q   <= data_out_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      data_valid_q <= data_valid_d;
    end
  end

  // The sample strobe marks the middle of the current bit.
  always_comb begin
    sample = 1'b0;
    unique case (state_q)
      S_START:                  sample = (clk_cnt_q == CNT_HALF);
      S_DATA, S_PARITY, S_STOP: sample = (clk_cnt_q == CNT_FULL);
      default:                  sample = 1'b0;
    endcase
  end

  // Even parity expects the XOR of the data bits. Odd parity expects its
  // inverse.
  assign par_exp  = (PARITY == 2) ? ^shift_q : ~^shift_q;
  assign ferr_now = ferr_q | ~rx_s;

  // NOTE: every signal written here gets a default first. Any path that does
  //       not assign it then holds the register value and infers no latch.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    data_valid_d = 1'b0;

    if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
      clk_cnt_d = sample ? CNT_ONE : clk_cnt_q + CNT_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d   = S_START;
          clk_cnt_d = CNT_ONE;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end

      S_START: begin
        if (sample) begin
          // A line that is high again at mid start bit was a glitch.
          state_d   = rx_s ? S_IDLE : S_DATA;
          bit_cnt_d = '0;
        end
      end

      S_DATA: begin
        if (sample) begin
          // Shift right so that the first (LSB) bit ends up in bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_PARITY: begin
        if (sample) begin
          perr_d    = (rx_s != par_exp);
          bit_cnt_d = '0;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (sample) begin
          ferr_d = ferr_now;
          if (bit_cnt_q == LAST_STOP) begin
            // Deliver even when an error flag is set. A low final stop bit
            // means a possible break, so wait for the line to go high again.
            data_out_d   = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_now;
            data_valid_d = 1'b1;
            state_d      = rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
//   Bench for uart_rx_param with three configurations, all at 16 clocks per
//   bit:
//     u0: 8 data bits, no parity, 1 stop bit
//     u1: 8 data bits, even parity, 1 stop bit
//     u2: 7 data bits, no parity, 2 stop bits
//   Stimulus pushes the expected frame into a per-instance queue. A monitor
//   for each instance pops and compares on every data_valid pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    int         cyc;   // expected cycle of the pulse, -1 = not checked
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1, rx2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, bz0, bz1, bz2;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q0[$], q1[$], q2[$];
  exp_t m0, m1, m2;

  uart_rx_param #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst(rst), .rx(rx0), .data_out(d0), .data_valid(dv0),
    .parity_err(pe0), .frame_err(fe0), .busy(bz0));

  uart_rx_param #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .data_out(d1), .data_valid(dv1),
    .parity_err(pe1), .frame_err(fe1), .busy(bz1));

  uart_rx_param #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .SYNC_STAGES(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx2), .data_out(d2), .data_valid(dv2),
    .parity_err(pe2), .frame_err(fe2), .busy(bz2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe, input int c);
    exp_t e;
    e.data = d; e.pe = pe; e.fe = fe; e.cyc = c;
    return e;
  endfunction

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Drives n bits (LSB first) for one bit period each. The caller is one time
  // unit after a rising edge, and the task returns with the same alignment.
  task automatic send_bits(input int inst, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(inst, bits[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("scoreboard drained", q0.size() + q1.size() + q2.size(), 0);
  endtask

  // Monitors, one per instance.
  always @(negedge clk) begin
    if (dv0) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL u0 unexpected data_valid: data=%0h fe=%0b pe=%0b", d0, fe0, pe0);
      end else begin
        m0 = q0.pop_front();
        check("u0 data_out", 32'(d0), 32'(m0.data));
        check("u0 parity_err", 32'(pe0), 32'(m0.pe));
        check("u0 frame_err", 32'(fe0), 32'(m0.fe));
        if (m0.cyc >= 0) check("u0 valid latency", cyc, m0.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (dv1) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL u1 unexpected data_valid: data=%0h fe=%0b pe=%0b", d1, fe1, pe1);
      end else begin
        m1 = q1.pop_front();
        check("u1 data_out", 32'(d1), 32'(m1.data));
        check("u1 parity_err", 32'(pe1), 32'(m1.pe));
        check("u1 frame_err", 32'(fe1), 32'(m1.fe));
      end
    end
  end

  always @(negedge clk) begin
    if (dv2) begin
      if (q2.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL u2 unexpected data_valid: data=%0h fe=%0b pe=%0b", d2, fe2, pe2);
      end else begin
        m2 = q2.pop_front();
        check("u2 data_out", 32'(d2), 32'(m2.data));
        check("u2 parity_err", 32'(pe2), 32'(m2.pe));
        check("u2 frame_err", 32'(fe2), 32'(m2.fe));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset u0 data_out", 32'(d0), 0);
    check("reset u0 data_valid", 32'(dv0), 0);
    check("reset u0 parity_err", 32'(pe0), 0);
    check("reset u0 frame_err", 32'(fe0), 0);
    check("reset u0 busy", 32'(bz0), 0);
    check("reset u1 busy", 32'(bz1), 0);
    check("reset u2 busy", 32'(bz2), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 1: 0xA5, 8N1. The pulse appears 9*16+8+2+1 = 155 edges after the fall.
    q0.push_back(mk(9'h0A5, 1'b0, 1'b0, cyc + 155));
    send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
    drain();
    check("u0 busy after frame", 32'(bz0), 0);

    // 2: even parity, 0x37 has five ones, so the parity bit is 1.
    q1.push_back(mk(9'h037, 1'b0, 1'b0, -1));
    send_bits(1, {1'b1, 1'b1, 8'h37, 1'b0}, 11);
    q1.push_back(mk(9'h037, 1'b1, 1'b0, -1));
    send_bits(1, {1'b1, 1'b0, 8'h37, 1'b0}, 11);
    drain();

    // 3: 5-cycle glitch. Detection is 2 edges after the fall. Check busy at
    //    detection+3 and detection+10.
    rx0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("u0 busy during glitch", 32'(bz0), 1);
    rx0 = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("u0 busy after glitch", 32'(bz0), 0);
    q0.push_back(mk(9'h03C, 1'b0, 1'b0, -1));
    send_bits(0, {1'b1, 8'h3C, 1'b0}, 10);
    drain();

    // 4: break held for 30 bit times. Expect a single frame_err frame of 0x00.
    q0.push_back(mk(9'h000, 1'b0, 1'b1, -1));
    rx0 = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    check("u0 busy in held break", 32'(bz0), 1);
    rx0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("u0 busy after break release", 32'(bz0), 0);
    repeat (CPB) @(posedge clk);
    #1;
    drain();

    // 5: 7 data bits, 2 stop bits, back-to-back frames, then a low second stop.
    q2.push_back(mk(9'h055, 1'b0, 1'b0, -1));
    q2.push_back(mk(9'h02A, 1'b0, 1'b0, -1));
    send_bits(2, {2'b11, 7'h55, 1'b0}, 10);
    send_bits(2, {2'b11, 7'h2A, 1'b0}, 10);
    q2.push_back(mk(9'h012, 1'b0, 1'b1, -1));
    send_bits(2, {1'b0, 1'b1, 7'h12, 1'b0}, 10);
    rx2 = 1'b1;
    drain();

    // 6: asynchronous reset during data bit 3 of 0xC3 (start, then bits 1,1,0
    //    sent, then mid bit 3).
    send_bits(0, 16'b0110, 4);
    rx0 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("u0 busy mid frame", 32'(bz0), 1);
    #2 rst = 1'b1;
    #1;
    check("async rst u0 busy", 32'(bz0), 0);
    check("async rst u0 frame_err", 32'(fe0), 0);
    check("async rst u0 data_valid", 32'(dv0), 0);
    check("async rst u0 data_out", 32'(d0), 0);
    check("async rst u0 parity_err", 32'(pe0), 0);
    check("async rst u1 data_out", 32'(d1), 0);
    check("async rst u1 parity_err", 32'(pe1), 0);
    check("async rst u2 frame_err", 32'(fe2), 0);
    check("async rst u2 data_out", 32'(d2), 0);
    rx0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    #1;
    q0.push_back(mk(9'h0C3, 1'b0, 1'b0, -1));
    send_bits(0, {1'b1, 8'hC3, 1'b0}, 10);
    drain();
    check("u0 busy at end", 32'(bz0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
